// File: rtl/if_inst_buffer.sv
// if_inst_buffer: in-order instruction queue between the IF2 predecoder and
// the ID decoder. It accepts up to two instructions per cycle and presents up
// to two. It back-pressures fetch when fewer than two slots are free, and it
// empties completely on a pipeline flush.
module if_inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  i_is_valid,
    input  logic [31:0] IR1,
    input  logic [31:0] IR2,
    input  logic [31:0] PC1,
    input  logic [31:0] PC2,
    input  logic [33:0] type_pcpre_1,
    input  logic [33:0] type_pcpre_2,
    output logic        in_ready,
    output logic        if_stall,
    output logic [1:0]  o_valid,
    output logic [31:0] o_IR1,
    output logic [31:0] o_IR2,
    output logic [31:0] o_PC1,
    output logic [31:0] o_PC2,
    output logic [33:0] o_type_pcpre1,
    output logic [33:0] o_type_pcpre2,
    input  logic        id_ready
);

    // Entry layout: {IR[97:66], PC[65:34], type_pcpre[33:0]}
    localparam int ENTRY_W = 98;

    // Push is allowed only while at least two slots are free, so a dual
    // push can never overrun the queue.
    localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0] TWO        = (PTR_W + 1)'(2);
    localparam logic [PTR_W:0] ONE        = (PTR_W + 1)'(1);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    logic [PTR_W-1:0]   wr_ptr_p1;
    logic               push_en;
    logic [1:0]         push_num;
    logic [1:0]         pop_num;
    logic               wr_a_en;
    logic               wr_b_en;
    logic [ENTRY_W-1:0] entry_slot1;
    logic [ENTRY_W-1:0] entry_slot2;
    logic [ENTRY_W-1:0] wr_a_data;
    logic [ENTRY_W-1:0] rd_entry [2];

    assign entry_slot1 = {IR1, PC1, type_pcpre_1};
    assign entry_slot2 = {IR2, PC2, type_pcpre_2};

    // Back-pressure looks only at the registered fill level. A pop in the
    // same cycle is deliberately ignored, which keeps this path short.
    assign in_ready = (count_reg <= PUSH_LIMIT);
    assign if_stall = ~in_ready;

    // Head-valid flags follow directly from the fill level.
    always_comb begin
        o_valid = 2'b00;
        if (count_reg >= TWO) begin
            o_valid = 2'b11;
        end else if (count_reg == ONE) begin
            o_valid = 2'b10;
        end
    end

    // Read ports: slot gi sees entry rd_ptr+gi. Pointer arithmetic wraps
    // naturally because DEPTH is a power of two.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_slot
        assign rd_entry[gi] = mem_reg[rd_ptr_reg + PTR_W'(gi)];
    end

    assign o_IR1         = rd_entry[0][97:66];
    assign o_PC1         = rd_entry[0][65:34];
    assign o_type_pcpre1 = rd_entry[0][33:0];
    assign o_IR2         = rd_entry[1][97:66];
    assign o_PC2         = rd_entry[1][65:34];
    assign o_type_pcpre2 = rd_entry[1][33:0];

    // Push/pop decode. A flush suppresses both.
    always_comb begin
        push_en  = in_ready && !flush && (i_is_valid != 2'b00);
        push_num = 2'd0;
        pop_num  = 2'd0;
        if (push_en) begin
            push_num = {1'b0, i_is_valid[1]} + {1'b0, i_is_valid[0]};
        end
        if (id_ready && !flush) begin
            pop_num = {1'b0, o_valid[1]} + {1'b0, o_valid[0]};
        end
    end

    // Port A always takes the oldest valid incoming instruction. Port B is
    // used only for slot 2 of a dual push, one entry after port A.
    assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);
    assign wr_a_en   = push_en;
    assign wr_b_en   = push_en && (i_is_valid == 2'b11);
    assign wr_a_data = i_is_valid[1] ? entry_slot1 : entry_slot2;

    // Entry storage: two write ports that never hit the same address.
    always_ff @(posedge clk) begin
        if (wr_a_en) begin
            mem_reg[wr_ptr_reg] <= wr_a_data;
        end
        if (wr_b_en) begin
            mem_reg[wr_ptr_p1] <= entry_slot2;
        end
    end

    // Pointer and occupancy bookkeeping. Reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_num);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_num);
            count_reg  <= count_reg + (PTR_W + 1)'(push_num) - (PTR_W + 1)'(pop_num);
        end
    end

endmodule

// File: tb/tb_if_inst_buffer.sv
// tb_if_inst_buffer: directed stimulus with a queue scoreboard for
// if_inst_buffer (DEPTH=16). Expected entries are queued when they are
// driven. They are compared against the head/head+1 outputs each cycle.
module tb_if_inst_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  i_is_valid;
    logic [31:0] IR1, IR2, PC1, PC2;
    logic [33:0] type_pcpre_1, type_pcpre_2;
    logic        in_ready, if_stall;
    logic [1:0]  o_valid;
    logic [31:0] o_IR1, o_IR2, o_PC1, o_PC2;
    logic [33:0] o_type_pcpre1, o_type_pcpre2;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [33:0] t;
    } ent_t;

    ent_t sb[$];
    ent_t nul;

    if_inst_buffer #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .i_is_valid   (i_is_valid),
        .IR1          (IR1),
        .IR2          (IR2),
        .PC1          (PC1),
        .PC2          (PC2),
        .type_pcpre_1 (type_pcpre_1),
        .type_pcpre_2 (type_pcpre_2),
        .in_ready     (in_ready),
        .if_stall     (if_stall),
        .o_valid      (o_valid),
        .o_IR1        (o_IR1),
        .o_IR2        (o_IR2),
        .o_PC1        (o_PC1),
        .o_PC2        (o_PC2),
        .o_type_pcpre1(o_type_pcpre1),
        .o_type_pcpre2(o_type_pcpre2),
        .id_ready     (id_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.ir = ~pc;
        e.pc = pc;
        e.t  = {2'b10, pc + 32'd8};
        return e;
    endfunction

    // Compare the current DUT outputs against the scoreboard head.
    task automatic check_outputs();
        int n;
        n = sb.size();
        chk("o_valid", {32'd0, o_valid}, {32'd0, (n >= 2) ? 2'b11 : (n == 1) ? 2'b10 : 2'b00});
        chk("in_ready", {33'd0, in_ready}, {33'd0, ((16 - n) >= 2)});
        chk("if_stall", {33'd0, if_stall}, {33'd0, !((16 - n) >= 2)});
        if (n >= 1) begin
            chk("o_IR1", {2'b0, o_IR1}, {2'b0, sb[0].ir});
            chk("o_PC1", {2'b0, o_PC1}, {2'b0, sb[0].pc});
            chk("o_type_pcpre1", o_type_pcpre1, sb[0].t);
        end
        if (n >= 2) begin
            chk("o_IR2", {2'b0, o_IR2}, {2'b0, sb[1].ir});
            chk("o_PC2", {2'b0, o_PC2}, {2'b0, sb[1].pc});
            chk("o_type_pcpre2", o_type_pcpre2, sb[1].t);
        end
    endtask

    // Drive one cycle of inputs, check the outputs, clock, and update the model.
    task automatic cycle(input logic fl, input logic [1:0] v, input ent_t e1,
                         input ent_t e2, input logic rdy);
        int  n;
        bit  acc;
        flush        = fl;
        i_is_valid   = v;
        IR1          = e1.ir;
        PC1          = e1.pc;
        type_pcpre_1 = e1.t;
        IR2          = e2.ir;
        PC2          = e2.pc;
        type_pcpre_2 = e2.t;
        id_ready     = rdy;
        check_outputs();
        n   = sb.size();
        acc = ((16 - n) >= 2);
        $display("txn t=%0t flush=%0b valid=%b pc1=%h pc2=%h id_ready=%0b occ=%0d accept=%0b",
                 $time, fl, v, e1.pc, e2.pc, rdy, n, acc && !fl);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy) begin
                repeat ((n >= 2) ? 2 : n) void'(sb.pop_front());
            end
            if (acc) begin
                if (v[1]) sb.push_back(e1);
                if (v[0]) sb.push_back(e2);
            end
        end
        #1;
    endtask

    initial begin
        ent_t a;
        ent_t b;
        nul          = '0;
        rst          = 1'b1;
        flush        = 1'b0;
        i_is_valid   = 2'b00;
        IR1          = '0;
        IR2          = '0;
        PC1          = '0;
        PC2          = '0;
        type_pcpre_1 = '0;
        type_pcpre_2 = '0;
        id_ready     = 1'b0;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_o_valid", {32'd0, o_valid}, 34'd0);
        chk("reset_in_ready", {33'd0, in_ready}, 34'd1);
        cycle(1'b0, 2'b00, nul, nul, 1'b0);
        cycle(1'b0, 2'b00, nul, nul, 1'b0);

        // Single dual push, then a decoder consume.
        a = '{ir: 32'h02800421, pc: 32'h1C000000, t: 34'h0_0000_0000};
        b = '{ir: 32'h02800842, pc: 32'h1C000004, t: 34'h1_1C00_0010};
        cycle(1'b0, 2'b11, a, b, 1'b0);
        chk("dual_pc1", {2'b0, o_PC1}, {2'b0, 32'h1C000000});
        chk("dual_pc2", {2'b0, o_PC2}, {2'b0, 32'h1C000004});
        cycle(1'b0, 2'b00, nul, nul, 1'b1);
        chk("dual_drained", {32'd0, o_valid}, 34'd0);

        // Fill to full; the last two pushes must be ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'b11, mk(32'h3000 + 32'(8 * i)), mk(32'h3004 + 32'(8 * i)), 1'b0);
        end
        chk("full_in_ready", {33'd0, in_ready}, 34'd0);
        chk("full_if_stall", {33'd0, if_stall}, 34'd1);
        cycle(1'b0, 2'b00, nul, nul, 1'b1);
        chk("after_pop_in_ready", {33'd0, in_ready}, 34'd1);
        repeat (8) cycle(1'b0, 2'b00, nul, nul, 1'b1);

        // Partial masks and ordering.
        cycle(1'b0, 2'b10, mk(32'h100), mk(32'hDEAD), 1'b0);
        cycle(1'b0, 2'b01, mk(32'hBEEF), mk(32'h108), 1'b1);
        chk("one_left_valid", {32'd0, o_valid}, 34'h2);
        chk("one_left_pc", {2'b0, o_PC1}, {2'b0, 32'h108});
        cycle(1'b0, 2'b11, mk(32'h200), mk(32'h204), 1'b1);
        cycle(1'b0, 2'b00, nul, nul, 1'b1);

        // Steady stream across the pointer wrap with simultaneous push/pop.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'b11, mk(32'h4000 + 32'(8 * i)), mk(32'h4004 + 32'(8 * i)), 1'b1);
        end
        chk("stream_pc1", {2'b0, o_PC1}, {2'b0, 32'h4098});
        cycle(1'b0, 2'b00, nul, nul, 1'b1);

        // Flush mid-stream with a push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b11, mk(32'h6000 + 32'(8 * i)), mk(32'h6004 + 32'(8 * i)), 1'b0);
        end
        cycle(1'b1, 2'b11, mk(32'h7000), mk(32'h7004), 1'b0);
        chk("flush_o_valid", {32'd0, o_valid}, 34'd0);
        chk("flush_in_ready", {33'd0, in_ready}, 34'd1);
        cycle(1'b0, 2'b11, mk(32'h5000), mk(32'h5004), 1'b0);
        chk("post_flush_pc1", {2'b0, o_PC1}, {2'b0, 32'h5000});
        cycle(1'b0, 2'b00, nul, nul, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_inst_buffer.md
Name: if_inst_buffer

Overview:
- Instruction buffer between the IF2 predecoder stage and the ID decoder.
- Accepts up to two predecoded instructions per cycle (IR, PC, 34-bit type/predicted-PC word) and queues them in program order.
- Presents up to two instructions per cycle to the decoder.
- Generates fetch back-pressure, and empties the queue on a pipeline flush (branch mispredict, exception, or predecoder redirect).

Parameters:
- DEPTH, 16, number of entries. Must be a power of 2 and at least 4.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all queued and incoming instructions this cycle.
- i_is_valid  input  2  per-slot valid from IF2. Bit1 is slot 1 (older instruction); bit0 is slot 2.
- IR1, IR2  input  32 each  instruction words for slot 1 and slot 2.
- PC1, PC2  input  32 each  PCs for slot 1 and slot 2.
- type_pcpre_1, type_pcpre_2  input  34 each  branch type plus predicted PC for slot 1 and slot 2.
- in_ready  output  1  buffer can accept two instructions this cycle.
- if_stall  output  1  equals ~in_ready; freezes the IF1/IF2 registers.
- o_valid  output  2  bit1: head entry valid; bit0: head+1 entry valid.
- o_IR1, o_IR2  output  32 each  head and head+1 instruction words.
- o_PC1, o_PC2  output  32 each  head and head+1 PCs.
- o_type_pcpre1, o_type_pcpre2  output  34 each  head and head+1 type/predicted-PC words.
- id_ready  input  1  decoder consumes every entry flagged in o_valid this cycle.

Behaviour:
- Storage: DEPTH entries of 98 bits each ({IR, PC, type_pcpre}), a circular buffer addressed by wr_ptr and rd_ptr (PTR_W bits each, wrap modulo DEPTH). An occupancy counter `count` (PTR_W+1 bits, range 0..DEPTH) tracks fill level.
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0. Next cycle o_valid=2'b00, in_ready=1, if_stall=0. Entry contents are don't-care.
- Flush (flush=1, rst=0): same pointer and count clearing as reset. Flush has priority over push and pop in the same cycle; nothing is enqueued or dequeued.
- in_ready = (DEPTH - count) >= 2. It is computed from the registered count only; a same-cycle pop is ignored.
- Push occurs when in_ready=1, no flush, and i_is_valid != 0. Program order is slot 1 before slot 2. Write rules by i_is_valid:
  - 2'b11: IR1 entry at wr_ptr, IR2 entry at wr_ptr+1; wr_ptr += 2.
  - 2'b10: IR1 entry only at wr_ptr; wr_ptr += 1.
  - 2'b01: IR2 entry only at wr_ptr; wr_ptr += 1.
  - 2'b00: no write.
- When in_ready=0, inputs are ignored. IF holds them, because if_stall=1.
- Outputs are combinational from registered state (no bypass):
  - o_valid = 2'b11 if count >= 2; 2'b10 if count == 1; 2'b00 if count == 0.
  - o_* slot 1 reads entry rd_ptr; o_* slot 2 reads entry rd_ptr+1 (wrapped).
- Latency: an instruction pushed at edge N appears on the outputs after edge N (visible in cycle N+1). Minimum one cycle from input to output.
- Pop occurs when id_ready=1 and no flush. rd_ptr advances by popcount(o_valid), i.e. 0, 1 or 2.
- Count update: count_next = count + pushes - pops. Simultaneous push and pop in one cycle is legal.
- Invariant: count never exceeds DEPTH. The in_ready rule guarantees two free slots before any push.
- Wrap-around: pointers wrap modulo DEPTH. A dual push at wr_ptr = DEPTH-1 writes entries DEPTH-1 and 0.
- Outputs while o_valid bits are 0 are don't-care. The bench checks data only on valid slots.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then i_is_valid=0 → o_valid=2'b00, in_ready=1, if_stall=0.
- Single dual push: cycle 0 push {IR1=0x02800421, PC1=0x1C000000; IR2=0x02800842, PC2=0x1C000004}, i_is_valid=2'b11, id_ready=0 → cycle 1: o_valid=2'b11, o_PC1=0x1C000000, o_PC2=0x1C000004. Next cycle with id_ready=1 → o_valid=2'b00.
- Fill to full: push 2'b11 every cycle with id_ready=0, DEPTH=16 → after 7 pushes (count=14) in_ready stays 1. After the 8th (count=16): in_ready=0, if_stall=1, further inputs ignored. Then one id_ready pulse → count=14, in_ready=1.
- Partial masks and ordering: push 2'b10 (PC 0x100), then 2'b01 (PC2 0x108), then 2'b11 (PC 0x200/0x204) → pop order PCs are 0x100, 0x108, 0x200, 0x204, with o_valid=2'b10 when exactly one entry remains.
- Wrap and simultaneous push/pop: steady stream of 2'b11 pushes with id_ready=1 for 20 cycles → count settles at 2. PCs emerge strictly increasing by 4 across the pointer wrap at entry 15→0, with no duplicates or drops.
- Flush mid-stream: with count=6 and a push of 2'b11 in the same cycle, assert flush=1 → next cycle o_valid=2'b00, count=0, in_ready=1. A push in the cycle after flush appears normally one cycle later.
